// File: rtl/alink_txc_pkg.sv
// rtl/alink_txc_pkg.sv - shared encodings and defaults for the ALINK TX arbiter
package alink_txc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RR    = 2'd0;
    localparam logic [1:0] MODE_PRIO  = 2'd1;
    localparam logic [1:0] MODE_BCAST = 2'd2;

    localparam int PHY_NUM_DEF = 32;
    localparam int TOUT_W_DEF  = 32;

endpackage

// File: rtl/alink_chan_timer.sv
// rtl/alink_chan_timer.sv - one channel's busy flag, elapsed timer and sticky timeout flag
module alink_chan_timer #(
    parameter int TOUT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_set,
    input  logic              i_result,
    input  logic [TOUT_W-1:0] i_tout,
    input  logic              i_tout_clr,
    output logic              o_busy,
    output logic [TOUT_W-1:0] o_timer,
    output logic              o_flag
);

    logic              r_busy;
    logic [TOUT_W-1:0] r_timer;
    logic              r_flag;
    logic              w_result;
    logic              w_tout_hit;

    // A result only counts against an outstanding task; it beats a coincident timeout.
    assign w_result   = r_busy && i_result;
    assign w_tout_hit = r_busy && (i_tout != '0) && (r_timer == i_tout - TOUT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_timer <= '0;
            r_flag  <= 1'b0;
        end else if (i_flush) begin
            r_busy  <= 1'b0;
            r_timer <= '0;
            r_flag  <= 1'b0;
        end else begin
            if (i_set) begin
                r_busy  <= 1'b1;
                r_timer <= '0;
            end else if (w_result || w_tout_hit) begin
                r_busy  <= 1'b0;
                r_timer <= '0;
            end else if (r_busy && (r_timer != '1)) begin
                r_timer <= r_timer + TOUT_W'(1);
            end

            if (w_tout_hit && !w_result) begin
                r_flag <= 1'b1;
            end else if (i_tout_clr) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_timer = r_timer;
    assign o_flag  = r_flag;

endmodule

// File: rtl/alink_txc_rr.sv
// rtl/alink_txc_rr.sv - TX channel arbiter: round-robin, fixed-priority or broadcast grant with per-channel timeouts
module alink_txc_rr
    import alink_txc_pkg::*;
#(
    parameter int PHY_NUM = PHY_NUM_DEF,
    parameter int TOUT_W  = TOUT_W_DEF,
    parameter int PTR_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reg_flush,
    input  logic [PHY_NUM-1:0]        reg_mask,
    input  logic [1:0]                reg_mode,
    input  logic [TOUT_W-1:0]         reg_tout,
    input  logic [PHY_NUM-1:0]        tout_clr,
    input  logic                      tx_task_vld,
    output logic                      tx_phy_start,
    output logic [PHY_NUM-1:0]        tx_phy_sel,
    input  logic                      tx_phy_done,
    input  logic                      task_id_vld,
    input  logic [PHY_NUM-1:0]        rx_phy_sel,
    output logic [PHY_NUM-1:0]        reg_busy,
    output logic [PHY_NUM-1:0]        tout_flag,
    output logic [TOUT_W*PHY_NUM-1:0] timer_cnt,
    output logic [1:0]                cur_state
);

    state_t             r_state;
    logic [PHY_NUM-1:0] r_sel;
    logic               r_start;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gidx;
    logic               r_grr;
    logic [PHY_NUM-1:0] w_elig;
    logic [PHY_NUM-1:0] w_grant;
    logic [PHY_NUM-1:0] w_set;
    logic               w_mode_rr;

    // Rotate eligibility so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    function automatic logic [PHY_NUM-1:0] f_grant(input logic [PHY_NUM-1:0] elig,
                                                   input logic [1:0]         mode,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [2*PHY_NUM-1:0] dbl;
        logic [PHY_NUM-1:0]   rot;
        logic [PHY_NUM-1:0]   low;
        dbl = {elig, elig} >> ptr;
        rot = dbl[PHY_NUM-1:0];
        low = rot & (~rot + PHY_NUM'(1));
        dbl = {low, low} << ptr;
        case (mode)
            MODE_PRIO:  f_grant = elig & (~elig + PHY_NUM'(1));
            MODE_BCAST: f_grant = elig;
            default:    f_grant = dbl[2*PHY_NUM-1:PHY_NUM];
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] f_idx(input logic [PHY_NUM-1:0] oh);
        f_idx = '0;
        for (int i = 0; i < PHY_NUM; i++) begin
            if (oh[i]) f_idx = PTR_W'(i);
        end
    endfunction

    assign w_elig    = ~reg_busy & ~reg_mask;
    assign w_grant   = f_grant(w_elig, reg_mode, r_ptr);
    assign w_mode_rr = (reg_mode != MODE_PRIO) && (reg_mode != MODE_BCAST);
    assign w_set     = (r_state == START) ? r_sel : '0;

    // The mode is latched at grant time so a later mode change cannot disturb the pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_start <= 1'b0;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grr   <= 1'b0;
        end else if (reg_flush) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_start <= 1'b0;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_grr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tx_task_vld && (w_elig != '0)) begin
                        r_sel   <= w_grant;
                        r_start <= 1'b1;
                        r_gidx  <= f_idx(w_grant);
                        r_grr   <= w_mode_rr;
                        r_state <= START;
                    end
                end
                START: begin
                    r_start <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (tx_phy_done) begin
                        r_sel   <= '0;
                        r_state <= IDLE;
                        if (r_grr) begin
                            r_ptr <= (r_gidx == PTR_W'(PHY_NUM - 1)) ? '0 : r_gidx + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_sel   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < PHY_NUM; g++) begin : g_chan
            alink_chan_timer #(
                .TOUT_W(TOUT_W)
            ) u_timer (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_flush   (reg_flush),
                .i_set     (w_set[g]),
                .i_result  (task_id_vld & rx_phy_sel[g]),
                .i_tout    (reg_tout),
                .i_tout_clr(tout_clr[g]),
                .o_busy    (reg_busy[g]),
                .o_timer   (timer_cnt[g*TOUT_W +: TOUT_W]),
                .o_flag    (tout_flag[g])
            );
        end
    endgenerate

    assign tx_phy_start = r_start;
    assign tx_phy_sel   = r_sel;
    assign cur_state    = r_state;

endmodule

// File: tb/tb_alink_txc_rr.sv
// tb/tb_alink_txc_rr.sv - directed self-checking bench for alink_txc_rr
module tb_alink_txc_rr;

    localparam int N  = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          reg_flush = 1'b0;
    logic [N-1:0]  reg_mask = '0;
    logic [1:0]    reg_mode = 2'd0;
    logic [TW-1:0] reg_tout = '0;
    logic [N-1:0]  tout_clr = '0;
    logic          tx_task_vld = 1'b0;
    logic          tx_phy_start;
    logic [N-1:0]  tx_phy_sel;
    logic          tx_phy_done = 1'b0;
    logic          task_id_vld = 1'b0;
    logic [N-1:0]  rx_phy_sel = '0;
    logic [N-1:0]  reg_busy;
    logic [N-1:0]  tout_flag;
    logic [TW*N-1:0] timer_cnt;
    logic [1:0]    cur_state;

    int n_checks = 0;
    int n_errors = 0;

    alink_txc_rr #(.PHY_NUM(N), .TOUT_W(TW), .PTR_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_flush   (reg_flush),
        .reg_mask    (reg_mask),
        .reg_mode    (reg_mode),
        .reg_tout    (reg_tout),
        .tout_clr    (tout_clr),
        .tx_task_vld (tx_task_vld),
        .tx_phy_start(tx_phy_start),
        .tx_phy_sel  (tx_phy_sel),
        .tx_phy_done (tx_phy_done),
        .task_id_vld (task_id_vld),
        .rx_phy_sel  (rx_phy_sel),
        .reg_busy    (reg_busy),
        .tout_flag   (tout_flag),
        .timer_cnt   (timer_cnt),
        .cur_state   (cur_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic result(input logic [N-1:0] ch);
        task_id_vld = 1'b1;
        rx_phy_sel  = ch;
        tick(1);
        task_id_vld = 1'b0;
        rx_phy_sel  = '0;
    endtask

    task automatic done_pulse();
        tx_phy_done = 1'b1;
        tick(1);
        tx_phy_done = 1'b0;
        check("done_idle", 64'(cur_state), 64'd0);
    endtask

    task automatic grant_to_wait();
        tx_task_vld = 1'b1;
        tick(1);
        tx_task_vld = 1'b0;
        tick(1);
    endtask

    // Full transfer: start one cycle after qualification, done three cycles after start.
    task automatic do_task(input string tag, input logic [N-1:0] exp_sel, input bit ret);
        tx_task_vld = 1'b1;
        tick(1);
        check({tag, "_start"}, 64'(tx_phy_start), 64'd1);
        check({tag, "_sel"}, 64'(tx_phy_sel), 64'(exp_sel));
        check({tag, "_nobusy_in_start"}, 64'(reg_busy & exp_sel), 64'd0);
        tx_task_vld = 1'b0;
        tick(1);
        check({tag, "_start_drop"}, 64'(tx_phy_start), 64'd0);
        check({tag, "_wait"}, 64'(cur_state), 64'd2);
        check({tag, "_busy_set"}, 64'(reg_busy & exp_sel), 64'(exp_sel));
        tick(1);
        tx_phy_done = 1'b1;
        tick(1);
        tx_phy_done = 1'b0;
        check({tag, "_idle"}, 64'(cur_state), 64'd0);
        check({tag, "_sel_clr"}, 64'(tx_phy_sel), 64'd0);
        if (ret) begin
            result(exp_sel);
            check({tag, "_busy_clr"}, 64'(reg_busy & exp_sel), 64'd0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_state", 64'(cur_state), 64'd0);
        check("rst_start", 64'(tx_phy_start), 64'd0);
        check("rst_sel", 64'(tx_phy_sel), 64'd0);
        check("rst_busy", 64'(reg_busy), 64'd0);
        check("rst_flag", 64'(tout_flag), 64'd0);
        check("rst_timer", 64'(timer_cnt), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Round-robin sequence, wrapping past channel 3.
        do_task("rr0", 4'b0001, 1'b1);
        do_task("rr1", 4'b0010, 1'b1);
        do_task("rr2", 4'b0100, 1'b1);
        do_task("rr3", 4'b1000, 1'b1);
        do_task("rr4", 4'b0001, 1'b1);

        // Mask/busy skip: ptr=1, channel 2 busy, channel 1 masked.
        reg_mode = 2'd1; reg_mask = 4'b1011;
        do_task("prio_c2", 4'b0100, 1'b0);
        reg_mode = 2'd0; reg_mask = 4'b0010;
        do_task("skip_c3", 4'b1000, 1'b1);
        do_task("skip_c0", 4'b0001, 1'b1);
        result(4'b0100);
        check("skip_busy_clr", 64'(reg_busy), 64'd0);

        // Broadcast with channel 1 busy and channel 3 masked.
        reg_mask = 4'b0000;
        do_task("rr_c1", 4'b0010, 1'b0);
        reg_mode = 2'd2; reg_mask = 4'b1000;
        do_task("bcast", 4'b0101, 1'b0);
        check("bcast_busy", 64'(reg_busy), 64'h7);
        result(4'b0001); result(4'b0010); result(4'b0100);
        check("bcast_busy_clr", 64'(reg_busy), 64'd0);

        // Timeout of 10 cycles on channel 0.
        reg_mode = 2'd1; reg_mask = 4'b0000; reg_tout = 4'd10;
        grant_to_wait();
        check("to_busy", 64'(reg_busy), 64'h1);
        tick(9);
        check("to_timer9", 64'(timer_cnt[TW-1:0]), 64'd9);
        check("to_busy9", 64'(reg_busy[0]), 64'd1);
        tick(1);
        check("to_busy10", 64'(reg_busy[0]), 64'd0);
        check("to_timer0", 64'(timer_cnt[TW-1:0]), 64'd0);
        check("to_flag", 64'(tout_flag), 64'h1);
        done_pulse();
        tick(2);
        check("to_flag_sticky", 64'(tout_flag), 64'h1);
        tout_clr = 4'b0001;
        tick(1);
        tout_clr = 4'b0000;
        check("to_flag_clr", 64'(tout_flag), 64'h0);

        grant_to_wait();
        tick(9);
        result(4'b0001);
        check("res_vs_to_busy", 64'(reg_busy), 64'h0);
        check("res_vs_to_flag", 64'(tout_flag), 64'h0);
        done_pulse();

        grant_to_wait();
        tick(9);
        tout_clr = 4'b0001;
        tick(1);
        tout_clr = 4'b0000;
        check("clr_vs_to_flag", 64'(tout_flag), 64'h1);
        done_pulse();

        // Flush in WAIT with busy=0011 and a sticky flag pending.
        reg_tout = 4'd0; reg_mode = 2'd2; reg_mask = 4'b1100;
        grant_to_wait();
        check("fl_busy", 64'(reg_busy), 64'h3);
        check("fl_sel", 64'(tx_phy_sel), 64'h3);
        tick(3);
        check("fl_timer1", 64'(timer_cnt[2*TW-1:TW]), 64'd3);
        reg_flush = 1'b1;
        tick(1);
        reg_flush = 1'b0;
        check("fl_state", 64'(cur_state), 64'd0);
        check("fl_busy0", 64'(reg_busy), 64'd0);
        check("fl_sel0", 64'(tx_phy_sel), 64'd0);
        check("fl_timers0", 64'(timer_cnt), 64'd0);
        check("fl_flag0", 64'(tout_flag), 64'd0);
        reg_mode = 2'd0; reg_mask = 4'b0000;
        do_task("fl_ptr0", 4'b0001, 1'b1);

        // Asynchronous reset mid-START.
        tx_task_vld = 1'b1;
        tick(1);
        check("ar_start", 64'(tx_phy_start), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_start_drop", 64'(tx_phy_start), 64'd0);
        check("ar_state", 64'(cur_state), 64'd0);
        check("ar_sel", 64'(tx_phy_sel), 64'd0);
        tx_task_vld = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Saturation with timeout disabled.
        grant_to_wait();
        check("sat_sel", 64'(tx_phy_sel), 64'h1);
        tick(20);
        check("sat_timer", 64'(timer_cnt[TW-1:0]), 64'd15);
        check("sat_busy", 64'(reg_busy[0]), 64'd1);
        check("sat_flag", 64'(tout_flag), 64'd0);
        done_pulse();
        result(4'b0001);
        result(4'b0010);
        check("ignore_nonbusy", 64'(reg_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alink_txc_rr.md
Name: alink_txc_rr

Overview:
- Parametrised next-generation ALINK TX arbiter. It sits between the TX FIFO/tx_phy and the rxc receive controller.
- It picks which PHY channel(s) receive the next task. Selection modes are round-robin, fixed-priority, or broadcast.
- It tracks per-channel busy state and runs per-channel timeout timers. Channels that time out are flagged with a sticky bit.
- It generalises the single-policy arbiter to any channel count and timer width.

Parameters:
PHY_NUM, 32, number of PHY channels (2..32)
TOUT_W, 32, width of timeout register and per-channel timers
PTR_W, 5, round-robin pointer width (must equal clog2(PHY_NUM))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
reg_flush  in  1  synchronous clear of all state
reg_mask  in  PHY_NUM  1 = channel disabled, never selected
reg_mode  in  2  0 round-robin, 1 fixed-priority (lowest index), 2 broadcast, 3 treated as 0
reg_tout  in  TOUT_W  timeout in cycles; 0 disables timeout
tout_clr  in  PHY_NUM  write-1 pulse clears matching tout_flag bits
tx_task_vld  in  1  at least one full task is present in the TX FIFO
tx_phy_start  out  1  one-cycle start pulse to tx_phy
tx_phy_sel  out  PHY_NUM  selected channel(s); held stable from start until done
tx_phy_done  in  1  tx_phy has finished shifting out the task
task_id_vld  in  1  rxc has a result for the channel given by rx_phy_sel
rx_phy_sel  in  PHY_NUM  one-hot returning channel
reg_busy  out  PHY_NUM  channel holds an outstanding task
tout_flag  out  PHY_NUM  sticky per-channel timeout flag
timer_cnt  out  TOUT_W*PHY_NUM  per-channel elapsed cycles; channel i occupies [i*TOUT_W +: TOUT_W]
cur_state  out  2  FSM state, for debug and the slave read-back

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - The FSM is in IDLE and the round-robin pointer is 0.
- reg_flush high for one cycle: next-edge state equals reset state, including clearing tout_flag. reg_flush takes priority over all other events.
- eligible = ~reg_busy & ~reg_mask.
- FSM encoding: IDLE=0, START=1, WAIT=2.
- IDLE:
  - If tx_task_vld and eligible != 0, register the grant into tx_phy_sel and go to START.
  - Otherwise remain in IDLE.
- Grant rules:
  - Mode 0: first eligible index at or above ptr, wrapping modulo PHY_NUM.
  - Mode 1: lowest eligible index.
  - Mode 2: all eligible bits.
  - Modes 0 and 1 produce a one-hot grant.
- START:
  - tx_phy_start = 1 for exactly one cycle.
  - The reg_busy bits for tx_phy_sel are set on the same edge that leaves START.
  - Go to WAIT.
- WAIT:
  - On tx_phy_done, go to IDLE and clear tx_phy_sel.
  - In mode 0, ptr becomes granted index + 1, wrapping PHY_NUM-1 -> 0.
  - In modes 1 and 2, ptr is unchanged.
- Latency: from the qualifying cycle in IDLE to the tx_phy_start pulse is 1 cycle. Back-to-back tasks have a minimum of 2 idle cycles between starts.
- Mask or mode change after the grant does not abort the transfer. It takes effect at the next IDLE evaluation.
- Busy clear, per channel i:
  - task_id_vld & rx_phy_sel[i] clears busy[i] and timer i.
  - A result for a non-busy channel is ignored.
- Timer i:
  - Increments each cycle while busy[i].
  - Saturates at all-ones.
  - Held at 0 when not busy.
- Timeout: if reg_tout != 0, busy[i] is set and timer i == reg_tout-1, then next edge clears busy[i] and timer i and sets tout_flag[i].
- Simultaneous events on one channel:
  - Result and timeout in the same cycle: the result wins and tout_flag is not set.
  - Busy set and clear in the same cycle cannot occur, since grants only go to non-busy channels.
  - tout_clr and a new timeout in the same cycle: the flag stays set.
- tx_phy_done outside WAIT is ignored.
- tx_task_vld falling during START/WAIT has no effect.

Decomposition:
- Package alink_txc_pkg holds:
  - state encoding constants (IDLE/START/WAIT);
  - mode constants (MODE_RR, MODE_PRIO, MODE_BCAST);
  - the default PHY_NUM and TOUT_W.
- Sub-module alink_chan_timer holds one channel's busy flag, timer and sticky flag, instantiated PHY_NUM times by generate.
- The rotate-and-priority-encode grant logic stays in the top as a function.

Test Plan:
1. RR basic: PHY_NUM=4, mask=0, mode 0, 5 tasks; each done 3 cycles after start; results returned before the next grant -> tx_phy_sel sequence 0001, 0010, 0100, 1000, 0001; start 1 cycle after IDLE qualification.
2. Mask/busy skip: mask=0010, channel 2 busy, ptr=1, mode 0 -> grant 1000; then ptr=0 -> grant 0001.
3. Broadcast: mode 2, mask=1000, channel 1 busy -> single start with sel=0101; reg_busy becomes 0111.
4. Timeout: reg_tout=10, grant channel 0, no result -> busy[0] clears exactly 10 cycles after being set; tout_flag[0]=1 until tout_clr[0] pulse; result and timeout in the same cycle -> flag stays 0.
5. Flush/reset mid-WAIT: reg_flush in WAIT with busy=0011 -> next cycle cur_state=0, busy=0, sel=0, timers 0; rst_n low asynchronously mid-START -> tx_phy_start drops immediately.
6. Wrap and saturation: TOUT_W=4, reg_tout=0, busy for 20 cycles -> timer holds 15 and no timeout; RR grant of channel 3 -> ptr wraps to 0.
